// File: rtl/bit_stego_pkg.sv
`default_nettype none
// ============================================================================
// bit_stego_pkg : shared FSM encodings and defaults for the LSB stego blocks
// Revision 1.0
// ============================================================================
package bit_stego_pkg;

  localparam int DEFAULT_BPS        = 16;
  localparam int DEFAULT_FRAME_SIZE = 8;

  typedef enum logic [1:0] {
    s_IDLE    = 2'b00,
    s_EXTRACT = 2'b01,
    s_STOP    = 2'b10
  } state_t;

  function automatic int frames_per_word(input int msg_width, input int frame_size);
    return msg_width / frame_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_extractor_seq_lsb_gather.sv
`default_nettype none
// ============================================================================
// lsb_gather : picks bit 0 of every BPS-wide sample in a frame
// Revision 1.0
// ============================================================================
module lsb_gather #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 8
) (
  input  logic [FRAME_SIZE*BPS-1:0] i_frame,
  output logic [FRAME_SIZE-1:0]     o_lsbs
);

  for (genvar k = 0; k < FRAME_SIZE; k++) begin : g_lsb
    assign o_lsbs[k] = i_frame[k*BPS];
  end

  // Upper sample bits carry audio only and are deliberately ignored.
  logic unused_upper;
  assign unused_upper = ^i_frame;

endmodule
`default_nettype wire

// File: rtl/bit_extractor_seq.sv
`default_nettype none
// ============================================================================
// bit_extractor_seq : recovers one LSB per sample and packs frames into words
// Optional: BIT_EXTRACTOR_FRAME_CNT_EN adds the out_frame_total counter port
// Revision 1.0
// ============================================================================
module bit_extractor_seq
  import bit_stego_pkg::*;
#(
  parameter int BPS        = DEFAULT_BPS,
  parameter int FRAME_SIZE = DEFAULT_FRAME_SIZE,
  parameter int MSG_WIDTH  = 32
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_enable,
  input  logic [FRAME_SIZE*BPS-1:0]  in_frame,
  input  logic                       in_clear,
  output logic [FRAME_SIZE-1:0]      out_message,
  output logic                       out_ready,
  output logic [MSG_WIDTH-1:0]       out_word,
  output logic                       out_word_valid,
  output logic                       out_busy,
  output logic                       out_overrun
`ifdef BIT_EXTRACTOR_FRAME_CNT_EN
  ,
  output logic [15:0]                out_frame_total
`endif
);

  localparam int FPW   = frames_per_word(MSG_WIDTH, FRAME_SIZE);
  localparam int CNT_W = (FPW > 1) ? $clog2(FPW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPW - 1);

  if ((MSG_WIDTH % FRAME_SIZE) != 0) begin : g_chk_msg_width
    $error("MSG_WIDTH must be a multiple of FRAME_SIZE");
  end
  if (BPS < 2) begin : g_chk_bps
    $error("BPS must be at least 2");
  end

  state_t                      state_q,      state_d;
  logic [FRAME_SIZE*BPS-1:0]   frame_q,      frame_d;
  logic [CNT_W-1:0]            cnt_q,        cnt_d;
  logic [MSG_WIDTH-1:0]        acc_q,        acc_d;
  logic [FRAME_SIZE-1:0]       message_q,    message_d;
  logic [MSG_WIDTH-1:0]        word_q,       word_d;
  logic                        ready_q,      ready_d;
  logic                        word_valid_q, word_valid_d;
  logic                        overrun_q,    overrun_d;
  logic [FRAME_SIZE-1:0]       gathered;

  lsb_gather #(
    .BPS        (BPS),
    .FRAME_SIZE (FRAME_SIZE)
  ) u_lsb_gather (
    .i_frame (frame_q),
    .o_lsbs  (gathered)
  );

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    message_d    = message_q;
    word_d       = word_q;
    ready_d      = 1'b0;
    word_valid_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      s_IDLE: begin
        if (in_clear) begin
          cnt_d = '0;
          acc_d = '0;
        end
        if (in_enable) begin
          frame_d = in_frame;
          state_d = s_EXTRACT;
        end
      end
      s_EXTRACT: begin
        overrun_d = in_enable;
        message_d = gathered;
        if (in_clear) begin
          cnt_d = '0;
          acc_d = '0;
        end else begin
          for (int i = 0; i < FPW; i++) begin
            if (cnt_q == CNT_W'(i)) acc_d[i*FRAME_SIZE +: FRAME_SIZE] = gathered;
          end
        end
        state_d = s_STOP;
      end
      s_STOP: begin
        overrun_d = in_enable;
        ready_d   = 1'b1;
        // A clear here drops the in-flight frame from the word being built.
        if (in_clear) begin
          cnt_d = '0;
          acc_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          word_d       = acc_q;
          word_valid_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = s_IDLE;
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= s_IDLE;
      frame_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      message_q    <= '0;
      word_q       <= '0;
      ready_q      <= 1'b0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      message_q    <= message_d;
      word_q       <= word_d;
      ready_q      <= ready_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_message    = message_q;
  assign out_ready      = ready_q;
  assign out_word       = word_q;
  assign out_word_valid = word_valid_q;
  assign out_overrun    = overrun_q;
  assign out_busy       = (state_q != s_IDLE);

`ifdef BIT_EXTRACTOR_FRAME_CNT_EN
  logic [15:0] frame_total_q, frame_total_d;

  always_comb begin
    frame_total_d = frame_total_q;
    if (in_clear) begin
      frame_total_d = '0;
    end else if ((state_q == s_STOP) && (frame_total_q != 16'hFFFF)) begin
      frame_total_d = frame_total_q + 16'd1;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) frame_total_q <= '0;
    else        frame_total_q <= frame_total_d;
  end

  assign out_frame_total = frame_total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_extractor_seq.sv
`default_nettype none
// ============================================================================
// tb_bit_extractor_seq : directed vector bench for bit_extractor_seq
// Revision 1.0
// ============================================================================
module tb_bit_extractor_seq;

  localparam int BPS = 16;
  localparam int FS  = 8;
  localparam int MW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_enable;
  logic [FS*BPS-1:0] in_frame;
  logic              in_clear;
  logic [FS-1:0]     out_message;
  logic              out_ready;
  logic [MW-1:0]     out_word;
  logic              out_word_valid;
  logic              out_busy;
  logic              out_overrun;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_extractor_seq #(.BPS(BPS), .FRAME_SIZE(FS), .MSG_WIDTH(MW)) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_enable      (in_enable),
    .in_frame       (in_frame),
    .in_clear       (in_clear),
    .out_message    (out_message),
    .out_ready      (out_ready),
    .out_word       (out_word),
    .out_word_valid (out_word_valid),
    .out_busy       (out_busy),
    .out_overrun    (out_overrun)
  );

  // clr: 0 none, 1 clear pulse in an idle cycle before the frame, 2 clear with enable
  typedef struct {
    logic [7:0]  lsbs;
    logic [14:0] upper;
    int          clr;
    logic        exp_wv;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FS*BPS-1:0] mk_frame(input logic [7:0] lsbs, input logic [14:0] upper);
    logic [FS*BPS-1:0] f;
    for (int k = 0; k < FS; k++) f[k*BPS +: BPS] = {upper, lsbs[k]};
    return f;
  endfunction

  task automatic run_frame(input vec_t v);
    @(negedge clk);
    if (v.clr == 1) begin
      in_clear = 1'b1;
      @(negedge clk);
      in_clear = 1'b0;
    end
    in_frame  = mk_frame(v.lsbs, v.upper);
    in_enable = 1'b1;
    in_clear  = (v.clr == 2);
    @(negedge clk);
    in_enable = 1'b0;
    in_clear  = 1'b0;
    check("busy_after_E0", 64'(out_busy), 64'd1);
    @(negedge clk);
    check("message_E1", 64'(out_message), 64'(v.lsbs));
    check("ready_low_E1", 64'(out_ready), 64'd0);
    @(negedge clk);
    check("ready_E2", 64'(out_ready), 64'd1);
    check("word_valid_E2", 64'(out_word_valid), 64'(v.exp_wv));
    check("word_E2", 64'(out_word), 64'(v.exp_word));
    check("busy_E2", 64'(out_busy), 64'd0);
    @(negedge clk);
    check("ready_low_E3", 64'(out_ready), 64'd0);
    check("word_valid_low_E3", 64'(out_word_valid), 64'd0);
    check("message_hold_E3", 64'(out_message), 64'(v.lsbs));
  endtask

  initial begin
    vecs[0]  = '{8'hA5, 15'h7FFF, 0, 1'b0, 32'h0};
    vecs[1]  = '{8'h11, 15'h0000, 1, 1'b0, 32'h0};
    vecs[2]  = '{8'h22, 15'h1234, 0, 1'b0, 32'h0};
    vecs[3]  = '{8'h33, 15'h5555, 0, 1'b0, 32'h0};
    vecs[4]  = '{8'h44, 15'h2AAA, 0, 1'b1, 32'h44332211};
    vecs[5]  = '{8'h55, 15'h0000, 0, 1'b0, 32'h44332211};
    vecs[6]  = '{8'h66, 15'h7FFF, 0, 1'b0, 32'h44332211};
    vecs[7]  = '{8'hDE, 15'h7FFF, 2, 1'b0, 32'h44332211};
    vecs[8]  = '{8'hAD, 15'h0F0F, 0, 1'b0, 32'h44332211};
    vecs[9]  = '{8'hBE, 15'h0000, 0, 1'b0, 32'h44332211};
    vecs[10] = '{8'hEF, 15'h3C3C, 0, 1'b1, 32'hEFBEADDE};

    rst       = 1'b1;
    in_enable = 1'b0;
    in_clear  = 1'b0;
    in_frame  = '0;
    #1;
    check("rst_message", 64'(out_message), 64'd0);
    check("rst_word", 64'(out_word), 64'd0);
    check("rst_ready", 64'(out_ready), 64'd0);
    check("rst_busy", 64'(out_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_frame(vecs[i]);

    // Enable held across E0 and E1: second frame dropped, one overrun pulse.
    @(negedge clk);
    in_frame  = mk_frame(8'h3C, 15'h0);
    in_enable = 1'b1;
    @(negedge clk);
    check("ovr_busy", 64'(out_busy), 64'd1);
    check("ovr_low_E0", 64'(out_overrun), 64'd0);
    in_frame = mk_frame(8'hC3, 15'h0);
    @(negedge clk);
    in_enable = 1'b0;
    check("ovr_pulse", 64'(out_overrun), 64'd1);
    check("ovr_message", 64'(out_message), 64'h3C);
    @(negedge clk);
    check("ovr_clear", 64'(out_overrun), 64'd0);
    check("ovr_ready", 64'(out_ready), 64'd1);
    check("ovr_wv", 64'(out_word_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ovr_single_ready", 64'(out_ready), 64'd0);
      check("ovr_single_pulse", 64'(out_overrun), 64'd0);
    end

    // Asynchronous reset between edges with non-zero outputs.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_message", 64'(out_message), 64'd0);
    check("arst_word", 64'(out_word), 64'd0);
    check("arst_ready", 64'(out_ready), 64'd0);
    check("arst_wv", 64'(out_word_valid), 64'd0);
    check("arst_overrun", 64'(out_overrun), 64'd0);
    check("arst_busy", 64'(out_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while in s_EXTRACT: frame is lost, no ready pulse.
    @(negedge clk);
    in_frame  = mk_frame(8'hFF, 15'h7FFF);
    in_enable = 1'b1;
    @(negedge clk);
    in_enable = 1'b0;
    check("xrst_busy_before", 64'(out_busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("xrst_busy_after", 64'(out_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("xrst_no_ready", 64'(out_ready), 64'd0);
    end
    check("xrst_message", 64'(out_message), 64'd0);

    run_frame('{8'h01, 15'h1111, 0, 1'b0, 32'h0});
    run_frame('{8'h02, 15'h2222, 0, 1'b0, 32'h0});
    run_frame('{8'h03, 15'h3333, 0, 1'b0, 32'h0});
    run_frame('{8'h04, 15'h4444, 0, 1'b1, 32'h04030201});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_extractor_seq.md
Name: bit_extractor_seq

Overview:
Receive-side counterpart of the LSB bit embedder. Takes frames of FRAME_SIZE audio samples, BPS bits per sample, from the stego stream and recovers one message bit per sample from each sample's LSB. Assembles consecutive per-frame bit groups into MSG_WIDTH-bit message words for the downstream message sink. Uses the same enable/ready strobe handshake style as the embedder.

Parameters:
- BPS, 16, bits per sample. Must be ≥2.
- FRAME_SIZE, 8, samples per frame, which is also message bits per frame.
- MSG_WIDTH, 32, bits per assembled message word. Must be an integer multiple of FRAME_SIZE; the implementation checks this at elaboration.

Ports:
- in_clk  input  1  clock; all logic on the rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_enable  input  1  frame-valid strobe. Accepted only in s_IDLE.
- in_frame  input  FRAME_SIZE*BPS  frame; sample k occupies bits [k*BPS +: BPS].
- in_clear  input  1  synchronous clear of the word accumulator and frame counter.
- out_message  output  FRAME_SIZE  bits extracted from the last frame; bit k = LSB of sample k.
- out_ready  output  1  one-cycle pulse; out_message is valid.
- out_word  output  MSG_WIDTH  last completed message word.
- out_word_valid  output  1  one-cycle pulse; out_word has been updated.
- out_busy  output  1  high whenever state ≠ s_IDLE.
- out_overrun  output  1  one-cycle pulse; an in_enable was dropped.

Behaviour:
- Reset:
  - All outputs go to 0 immediately on in_rst.
  - state = s_IDLE; frame counter = 0; accumulator = 0.
  - Reset mid-operation discards the in-flight frame and any partial word. No ready or valid pulse is produced for them.
- State s_IDLE:
  - If in_enable = 1, latch in_frame into an internal register and go to s_EXTRACT.
  - Otherwise hold state.
- State s_EXTRACT (one cycle):
  - Register out_message[k] = latched_frame[k*BPS] for k in 0..FRAME_SIZE-1.
  - Write the same bits into accumulator bits [cnt*FRAME_SIZE +: FRAME_SIZE]. The first frame of a word lands in the LSBs.
  - Go to s_STOP.
- State s_STOP (one cycle):
  - out_ready = 1.
  - If cnt = MSG_WIDTH/FRAME_SIZE-1: copy the accumulator to out_word, pulse out_word_valid in this same cycle, and set cnt = 0.
  - Otherwise cnt = cnt+1.
  - Go to s_IDLE.
- Latency:
  - in_enable is sampled at edge E0.
  - out_message updates at E1.
  - out_ready (and out_word_valid when the word completes) is high from E2 to E3, exactly one cycle.
  - Maximum throughput is one frame per 3 cycles.
- Hold and drop rules:
  - out_message and out_word hold their values until the next update. They are not cleared when out_ready falls.
  - in_enable = 1 while out_busy = 1: the frame is dropped and out_overrun pulses for one cycle on the next edge. No other state changes.
- in_clear:
  - Sets cnt and the accumulator to 0. out_word and out_message are unaffected.
  - In s_EXTRACT or s_STOP, the clear takes priority over that state's cnt and accumulator update. The in-flight frame is still presented on out_message and out_ready, but it is not counted toward a word.
  - in_clear and in_enable together in s_IDLE: the clear applies and the frame is accepted as frame 0 of a new word.
- Counter width: $clog2(MSG_WIDTH/FRAME_SIZE), minimum 1 bit. Wrap-around happens only via the s_STOP rule above.
- Non-LSB sample bits are ignored entirely.

Optional Feature:
- Macro: BIT_EXTRACTOR_FRAME_CNT_EN.
- When defined, adds output out_frame_total [15:0]:
  - counts accepted frames, incremented in s_STOP;
  - saturates at 16'hFFFF;
  - reset value 0; cleared by in_clear;
  - dropped frames are not counted.
- When undefined, the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package bit_stego_pkg holds:
  - state encodings s_IDLE = 2'b00, s_EXTRACT = 2'b01, s_STOP = 2'b10;
  - default BPS and FRAME_SIZE, shared with the embedder;
  - function frames_per_word(MSG_WIDTH, FRAME_SIZE).
- One natural sub-module, lsb_gather: a combinational slice taking frame → FRAME_SIZE LSBs, parameterised by BPS and FRAME_SIZE. The embedder can reuse its indexing.

Test Plan:
All scenarios use BPS=16, FRAME_SIZE=8, MSG_WIDTH=32.
1. in_rst pulsed asynchronously between edges → all outputs 0 immediately; out_busy = 0.
2. One frame whose sample LSBs encode 8'hA5, with upper bits 15'h7FFF → out_message = 8'hA5. out_ready is high exactly one cycle, at E2; out_word_valid stays 0.
3. Four frames with LSBs 8'h11, 8'h22, 8'h33, 8'h44 → out_word = 32'h44332211. out_word_valid coincides with the 4th out_ready; the counter wraps so a 5th frame starts a new word.
4. in_enable high at E0 and E1 → second frame dropped. out_overrun pulses once after E1; only one out_ready occurs.
5. Two frames, then in_clear, then four frames 8'hDE, 8'hAD, 8'hBE, 8'hEF → out_word = 32'hEFBEADDE; no word_valid after the first two frames.
6. in_rst asserted while in s_EXTRACT → no out_ready; the next four frames produce a full word from scratch.
